operand_map_pipe: RTL and testbench



---
 rtl/operand_map_pipe_pkg.sv | 17 +
 rtl/operand_mux.sv | 76 +++++++
 rtl/operand_map_pipe.sv | 116 +++++++++++
 tb/tb_operand_map_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_map_pipe_pkg.sv
// Shared DSP operand geometry for the operand mapping pipeline.
// Pure constants; no logic, no latency.
// No flow control of its own.
package operand_map_pipe_pkg;

  // DSP slice port widths
  localparam int A_W = 30;
  localparam int B_W = 18;
  localparam int C_W = 48;

  // Operand width fed to the hard multiplier
  localparam int MULT_W = 16;

  // Low immediate field that can be routed onto port B
  localparam int IMM_B_W = 11;

endpackage : operand_map_pipe_pkg

// File: rtl/operand_mux.sv
// Combinational operand selection onto DSP ports A/B/C.
// Zero latency; purely combinational.
// No backpressure; the enclosing pipeline qualifies the result with valid.
module operand_mux
  import operand_map_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              usemult,
  input  logic              signmult,
  input  logic              useimm,
  input  logic              usemov,
  input  logic              seta0,
  input  logic              setb0,
  input  logic              setc0,
  input  logic [IMM_W-1:0]  data_imm,
  input  logic [DATA_W-1:0] data_ra,
  input  logic [DATA_W-1:0] data_rb,
  input  logic [DATA_W-1:0] data_rc,
  output logic [A_W-1:0]    data_a,
  output logic [B_W-1:0]    data_b,
  output logic [C_W-1:0]    data_c
);

  // Upper part of rb above the B field, sign-extended onto port A.
  // With an 18-bit operand there is nothing above the B field, so A is zero.
  logic [A_W-1:0] a_linear;

  generate
    if (DATA_W > B_W) begin : g_hi
      assign a_linear = A_W'($signed(data_rb[DATA_W-1:B_W]));
    end else begin : g_no_hi
      assign a_linear = '0;
    end
  endgenerate

  // Only the low multiplier-width slice of rc ever reaches a port.
  logic unused_rc_hi;
  assign unused_rc_hi = ^data_rc[DATA_W-1:MULT_W];

  // Select mapping, then apply immediate overrides, then force-to-zero overrides.
  always_comb begin
    data_a = '0;
    data_b = '0;
    data_c = '0;

    if (usemult) begin
      if (signmult) begin
        data_a = A_W'($signed(data_rb[MULT_W-1:0]));
        data_b = B_W'($signed(data_rc[MULT_W-1:0]));
      end else begin
        data_a = A_W'(data_rb[MULT_W-1:0]);
        data_b = B_W'(data_rc[MULT_W-1:0]);
      end
    end else begin
      data_a = a_linear;
      data_b = data_rb[B_W-1:0];
    end

    if (useimm) begin
      data_b = B_W'($signed(data_imm[IMM_B_W-1:0]));
    end

    if (usemov) begin
      data_c = C_W'($signed(data_imm));
    end else begin
      data_c = C_W'($signed(data_ra));
    end

    if (seta0) data_a = '0;
    if (setb0) data_b = '0;
    if (setc0) data_c = '0;
  end

endmodule : operand_mux

// File: rtl/operand_map_pipe.sv
// Maps register/immediate operands onto DSP ports A/B/C through a register pipeline.
// LATENCY cycles from capture to valid_o when not stalled; one result per cycle.
// stall_i freezes every stage; flush_i drops all in-flight entries and wins over stall.
module operand_map_pipe
  import operand_map_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              usemult_i,
  input  logic              signmult_i,
  input  logic              useimm_i,
  input  logic              usemov_i,
  input  logic              seta0_i,
  input  logic              setb0_i,
  input  logic              setc0_i,
  input  logic [IMM_W-1:0]  data_imm_i,
  input  logic [DATA_W-1:0] data_ra_i,
  input  logic [DATA_W-1:0] data_rb_i,
  input  logic [DATA_W-1:0] data_rc_i,
  output logic [A_W-1:0]    data_a_o,
  output logic [B_W-1:0]    data_b_o,
  output logic [C_W-1:0]    data_c_o,
  output logic              valid_o,
  output logic              busy_o
);

  logic [A_W-1:0] map_a;
  logic [B_W-1:0] map_b;
  logic [C_W-1:0] map_c;

  operand_mux #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_mux (
    .usemult  (usemult_i),
    .signmult (signmult_i),
    .useimm   (useimm_i),
    .usemov   (usemov_i),
    .seta0    (seta0_i),
    .setb0    (setb0_i),
    .setc0    (setc0_i),
    .data_imm (data_imm_i),
    .data_ra  (data_ra_i),
    .data_rb  (data_rb_i),
    .data_rc  (data_rc_i),
    .data_a   (map_a),
    .data_b   (map_b),
    .data_c   (map_c)
  );

  logic           stg_vld [LATENCY];
  logic [A_W-1:0] stg_a   [LATENCY];
  logic [B_W-1:0] stg_b   [LATENCY];
  logic [C_W-1:0] stg_c   [LATENCY];

  generate
    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
      logic           prev_vld;
      logic [A_W-1:0] prev_a;
      logic [B_W-1:0] prev_b;
      logic [C_W-1:0] prev_c;

      if (i == 0) begin : g_head
        assign prev_vld = valid_i;
        assign prev_a   = map_a;
        assign prev_b   = map_b;
        assign prev_c   = map_c;
      end else begin : g_body
        assign prev_vld = stg_vld[i-1];
        assign prev_a   = stg_a[i-1];
        assign prev_b   = stg_b[i-1];
        assign prev_c   = stg_c[i-1];
      end

      // Stage register: reset > flush > stall; data only follows valid entries.
      always_ff @(posedge clk) begin
        if (rst) begin
          stg_vld[i] <= 1'b0;
          stg_a[i]   <= '0;
          stg_b[i]   <= '0;
          stg_c[i]   <= '0;
        end else if (flush_i) begin
          stg_vld[i] <= 1'b0;
        end else if (!stall_i) begin
          stg_vld[i] <= prev_vld;
          if (prev_vld) begin
            stg_a[i] <= prev_a;
            stg_b[i] <= prev_b;
            stg_c[i] <= prev_c;
          end
        end
      end
    end
  endgenerate

  // Busy whenever any stage still carries a live entry.
  always_comb begin
    busy_o = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      busy_o = busy_o | stg_vld[k];
    end
  end

  assign valid_o  = stg_vld[LATENCY-1];
  assign data_a_o = stg_a[LATENCY-1];
  assign data_b_o = stg_b[LATENCY-1];
  assign data_c_o = stg_c[LATENCY-1];

endmodule : operand_map_pipe

// File: tb/tb_operand_map_pipe.sv
// Directed self-checking bench for operand_map_pipe at default parameters.
// Expected values are hand-computed constants.
// Outputs sampled 1 time unit after each rising edge.
module tb_operand_map_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_i, flush_i;
  logic        usemult_i, signmult_i, useimm_i, usemov_i;
  logic        seta0_i, setb0_i, setc0_i;
  logic [15:0] data_imm_i;
  logic [31:0] data_ra_i, data_rb_i, data_rc_i;
  logic [29:0] data_a_o;
  logic [17:0] data_b_o;
  logic [47:0] data_c_o;
  logic        valid_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  operand_map_pipe #(
    .DATA_W  (32),
    .IMM_W   (16),
    .LATENCY (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .usemult_i  (usemult_i),
    .signmult_i (signmult_i),
    .useimm_i   (useimm_i),
    .usemov_i   (usemov_i),
    .seta0_i    (seta0_i),
    .setb0_i    (setb0_i),
    .setc0_i    (setc0_i),
    .data_imm_i (data_imm_i),
    .data_ra_i  (data_ra_i),
    .data_rb_i  (data_rb_i),
    .data_rc_i  (data_rc_i),
    .data_a_o   (data_a_o),
    .data_b_o   (data_b_o),
    .data_c_o   (data_c_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 0; stall_i = 0; flush_i = 0;
    usemult_i = 0; signmult_i = 0; useimm_i = 0; usemov_i = 0;
    seta0_i = 0; setb0_i = 0; setc0_i = 0;
    data_imm_i = '0; data_ra_i = '0; data_rb_i = '0; data_rc_i = '0;
  endtask

  // Present one non-mult entry whose B field identifies it.
  task automatic send_tag(input logic [31:0] rb);
    valid_i   = 1;
    data_rb_i = rb;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    check_eq("rst_a", 64'(data_a_o), 64'h0);
    check_eq("rst_b", 64'(data_b_o), 64'h0);
    check_eq("rst_c", 64'(data_c_o), 64'h0);
    check_eq("rst_valid", 64'(valid_o), 64'h0);
    check_eq("rst_busy", 64'(busy_o), 64'h0);

    // Non-mult mapping, single entry, latency 2
    valid_i = 1; data_rb_i = 32'h8004_0003; data_ra_i = 32'h1234_5678;
    tick();
    check_eq("nm_busy_s0", 64'(busy_o), 64'h1);
    check_eq("nm_valid_early", 64'(valid_o), 64'h0);
    idle_inputs();
    tick();
    check_eq("nm_valid", 64'(valid_o), 64'h1);
    check_eq("nm_a", 64'(data_a_o), 64'h3FFF_E001);
    check_eq("nm_b", 64'(data_b_o), 64'h0_0003);
    check_eq("nm_c", 64'(data_c_o), 64'h0000_1234_5678);
    tick();
    check_eq("nm_valid_once", 64'(valid_o), 64'h0);
    check_eq("nm_busy_drain", 64'(busy_o), 64'h0);
    check_eq("nm_a_bubble_hold", 64'(data_a_o), 64'h3FFF_E001);

    // Mult signed then unsigned, back-to-back
    usemult_i = 1; signmult_i = 1; valid_i = 1;
    data_rb_i = 32'h0000_FFFF; data_rc_i = 32'h0000_8000; data_ra_i = 32'h8000_0000;
    tick();
    signmult_i = 0; data_ra_i = 32'h0000_0001;
    tick();
    idle_inputs();
    check_eq("ms_valid", 64'(valid_o), 64'h1);
    check_eq("ms_a", 64'(data_a_o), 64'h3FFF_FFFF);
    check_eq("ms_b", 64'(data_b_o), 64'h3_8000);
    check_eq("ms_c", 64'(data_c_o), 64'hFFFF_8000_0000);
    tick();
    check_eq("mu_valid", 64'(valid_o), 64'h1);
    check_eq("mu_a", 64'(data_a_o), 64'h0000_FFFF);
    check_eq("mu_b", 64'(data_b_o), 64'h0_8000);
    check_eq("mu_c", 64'(data_c_o), 64'h0000_0000_0001);
    tick();
    check_eq("mu_valid_end", 64'(valid_o), 64'h0);

    // Immediate routing and force-to-zero overrides, streamed
    valid_i = 1; useimm_i = 1; usemov_i = 1; data_imm_i = 16'h0400;
    data_rb_i = 32'h0000_0005;
    tick();
    setb0_i = 1;
    tick();
    check_eq("imm_b", 64'(data_b_o), 64'h3_FC00);
    check_eq("imm_c", 64'(data_c_o), 64'h0000_0000_0400);
    setb0_i = 0; setc0_i = 1; seta0_i = 1; data_rb_i = 32'hFFFF_FFFF;
    tick();
    check_eq("setb0_b", 64'(data_b_o), 64'h0);
    check_eq("setb0_c", 64'(data_c_o), 64'h0000_0000_0400);
    seta0_i = 0; setc0_i = 0; data_imm_i = 16'h8001; useimm_i = 0;
    data_rb_i = 32'h0000_0000;
    tick();
    check_eq("setc0_c", 64'(data_c_o), 64'h0);
    check_eq("seta0_a", 64'(data_a_o), 64'h0);
    idle_inputs();
    tick();
    check_eq("immneg_c", 64'(data_c_o), 64'hFFFF_FFFF_8001);
    check_eq("immneg_b", 64'(data_b_o), 64'h0_0000);
    tick();

    // Stream of 4 with a 3-cycle stall in the middle
    send_tag(32'h0000_0011); tick();
    send_tag(32'h0000_0022); tick();
    check_eq("st_out1", 64'(data_b_o), 64'h11);
    send_tag(32'h0000_0033); tick();
    check_eq("st_out2", 64'(data_b_o), 64'h22);
    stall_i = 1; send_tag(32'h0000_00EE);
    for (int s = 0; s < 3; s++) begin
      tick();
      check_eq($sformatf("st_frz_b%0d", s), 64'(data_b_o), 64'h22);
      check_eq($sformatf("st_frz_v%0d", s), 64'(valid_o), 64'h1);
    end
    stall_i = 0; send_tag(32'h0000_0044); tick();
    check_eq("st_out3", 64'(data_b_o), 64'h33);
    check_eq("st_out3_v", 64'(valid_o), 64'h1);
    idle_inputs(); tick();
    check_eq("st_out4", 64'(data_b_o), 64'h44);
    check_eq("st_out4_v", 64'(valid_o), 64'h1);
    tick();
    check_eq("st_end_v", 64'(valid_o), 64'h0);
    check_eq("st_end_busy", 64'(busy_o), 64'h0);

    // Flush with stall, two entries in flight
    send_tag(32'h0000_0055); tick();
    send_tag(32'h0000_0066); tick();
    check_eq("fl_pre_busy", 64'(busy_o), 64'h1);
    flush_i = 1; stall_i = 1; send_tag(32'h0000_0077);
    tick();
    check_eq("fl_valid", 64'(valid_o), 64'h0);
    check_eq("fl_busy", 64'(busy_o), 64'h0);
    idle_inputs(); tick();
    check_eq("fl_valid_1", 64'(valid_o), 64'h0);
    tick();
    check_eq("fl_valid_2", 64'(valid_o), 64'h0);
    check_eq("fl_busy_2", 64'(busy_o), 64'h0);

    // Reset with an entry in flight, then a fresh entry
    send_tag(32'h0000_0088); data_ra_i = 32'h0000_0099; tick();
    check_eq("rs_busy_pre", 64'(busy_o), 64'h1);
    rst = 1; flush_i = 0; stall_i = 1; send_tag(32'h0000_00AA);
    tick();
    rst = 0; stall_i = 0;
    check_eq("rs_a", 64'(data_a_o), 64'h0);
    check_eq("rs_b", 64'(data_b_o), 64'h0);
    check_eq("rs_c", 64'(data_c_o), 64'h0);
    check_eq("rs_valid", 64'(valid_o), 64'h0);
    check_eq("rs_busy", 64'(busy_o), 64'h0);
    send_tag(32'h0000_00BB); data_ra_i = 32'h0; tick();
    idle_inputs();
    check_eq("rs_new_early", 64'(valid_o), 64'h0);
    tick();
    check_eq("rs_new_valid", 64'(valid_o), 64'h1);
    check_eq("rs_new_b", 64'(data_b_o), 64'hBB);
    tick();
    check_eq("rs_new_once", 64'(valid_o), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_operand_map_pipe
